sub_bytes_engine: RTL and testbench
===================================

SUB_BYTES_ENGINE -- requirements
Module: sub_bytes_engine

Interface
REQ-001 Parameter LANES, default 4: number of S-box lanes applied per cycle; legal values 1, 2, 4, 8, 16.
REQ-002 Parameter STATE_BYTES, fixed 16: bytes per AES state block; not overridable.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port in_valid, input, 1: in_state carries a block to substitute.
REQ-006 Port in_ready, output, 1: engine accepts a block this cycle.
REQ-007 Port in_state, input, 128: input block; byte k occupies bits [8k+7:8k].
REQ-008 Port inv_mode, input, 1: selects the inverse S-box; sampled at accept.
REQ-009 Port out_valid, output, 1: out_state holds a completed block.
REQ-010 Port out_ready, input, 1: consumer takes out_state this cycle.
REQ-011 Port out_state, output, 128: substituted block, same byte order as in_state.
REQ-012 Port busy, output, 1: high whenever FSM is not IDLE.

Function
REQ-013 FSM states: IDLE, BUSY, DONE; in_ready = (state == IDLE); out_valid = (state == DONE).
REQ-014 Accept = in_valid & in_ready; on accept: load in_state into working register, latch inv_mode, clear lane counter, go to BUSY.
REQ-015 Each BUSY cycle: replace bytes [cnt*LANES .. cnt*LANES+LANES-1] with their S-box image; increment cnt.
REQ-016 When cnt == 16/LANES-1 in BUSY, the final group is written and the FSM goes to DONE on the same edge.
REQ-017 Latency: out_valid rises exactly 16/LANES cycles after the accept edge (LANES=4 -> 4 cycles; LANES=16 -> 1 cycle).
REQ-018 Forward S-box is the FIPS-197 SubBytes table, e.g. 00->63, FF->16, AA->AC, F0->8C, 0F->76.
REQ-019 out_state and out_valid hold stable in DONE until out_valid & out_ready; on that edge, go to IDLE.
REQ-020 No overlap: a new block is not accepted in the DONE-to-IDLE handshake cycle; earliest re-accept is the following cycle.
REQ-021 in_state and inv_mode changes while BUSY or DONE have no effect on the block in flight.
REQ-022 out_state is undefined-free: it always equals the working register, including during BUSY.
REQ-023 Illegal LANES value: elaboration fails via a generate-time error, not silent truncation.

Reset
REQ-024 reset high at any edge, including mid-BUSY or in DONE, forces IDLE, cnt=0, working register=0, latched mode=0; the in-flight block is discarded.
REQ-025 Reset outputs: in_ready=1, out_valid=0, busy=0, out_state=128'h0.
REQ-026 reset has priority over a simultaneous accept or output handshake.

Configuration
REQ-027 Macro SUB_BYTES_INV_SBOX_EN defined: LANES inverse S-box instances are built; latched inv_mode=1 applies InvSubBytes (63->00, 16->FF, AC->AA, 8C->F0, 76->0F).
REQ-028 Macro SUB_BYTES_INV_SBOX_EN undefined: no inverse tables built; inv_mode is ignored and the forward S-box is always applied; port list unchanged.

Verification
REQ-029 LANES=4, reset, accept in_state=128'h0 -> out_valid 4 cycles later, out_state=128'h6363...63 (all 16 bytes 63).
REQ-030 LANES=4, in_state bytes 00,FF,AA,F0,0F repeating from byte 0 -> out bytes 63,16,AC,8C,76 in matching positions; out_state held 3 cycles with out_ready=0, released on out_ready=1.
REQ-031 LANES=1 and LANES=16 builds, in_state=128'hFF..FF -> out_state=128'h16..16 after 16 and 1 cycles respectively.
REQ-032 reset asserted 2 cycles after accept (LANES=4) -> next cycle in_ready=1, out_valid=0, out_state=0; a fresh block then completes normally.
REQ-033 SUB_BYTES_INV_SBOX_EN defined, inv_mode=1, in_state=128'h6363...63 -> out_state=0; inv_mode toggled during BUSY does not change the result.
REQ-034 Back-to-back: in_valid held high with out_ready=1 -> accepts spaced 16/LANES+2 cycles apart, each block's output correct and never dropped.

Source files
------------

// File: rtl/sub_bytes_engine.sv
// AES SubBytes engine: substitutes a 16-byte state LANES bytes per cycle behind a valid/ready handshake.
// Define SUB_BYTES_INV_SBOX_EN to build the inverse S-box lanes (InvSubBytes when inv_mode is latched high).
module sub_bytes_engine #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         inv_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int STATE_BYTES = 16;
  localparam int GROUPS      = STATE_BYTES / LANES;
  localparam int CNT_W       = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam logic [CNT_W-1:0] LAST_GROUP = CNT_W'(GROUPS - 1);

  generate
    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
      $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  // The S-box is built from its algebraic definition (GF(2^8) inverse plus
  // affine map) rather than a 256-entry table.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // a^254 == a^-1 for a != 0, and maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] t;
    r = 8'h01;
    t = gf_mul(a, a);
    for (int i = 1; i < 8; i++) begin
      r = gf_mul(r, t);
      t = gf_mul(t, t);
    end
    return r;
  endfunction

  function automatic logic [7:0] fwd_sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

`ifdef SUB_BYTES_INV_SBOX_EN
  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
  endfunction
`endif

  state_t                          state;
  logic [CNT_W-1:0]                cnt;
  logic [STATE_BYTES-1:0][7:0]     work;
  logic [STATE_BYTES-1:0][7:0]     work_next;
  logic [7:0]                      lane_in  [LANES];
  logic [7:0]                      lane_out [LANES];

`ifdef SUB_BYTES_INV_SBOX_EN
  logic inv_q;
`else
  logic unused_inv_mode;
  assign unused_inv_mode = inv_mode;
`endif

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_in[l] = work[4'(int'(cnt) * LANES + l)];
    end
  end

  generate
    for (genvar l = 0; l < LANES; l++) begin : g_lane
`ifdef SUB_BYTES_INV_SBOX_EN
      assign lane_out[l] = inv_q ? inv_sbox(lane_in[l]) : fwd_sbox(lane_in[l]);
`else
      assign lane_out[l] = fwd_sbox(lane_in[l]);
`endif
    end
  endgenerate

  always_comb begin
    // NOTE: full default before the selective overwrite keeps this purely combinational (no latch).
    work_next = work;
    for (int l = 0; l < LANES; l++) begin
      work_next[4'(int'(cnt) * LANES + l)] = lane_out[l];
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every update sees pre-edge values;
    // the working register is a plain flop bank, so clearing it on reset is cheap and keeps out_state defined.
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      work  <= '0;
`ifdef SUB_BYTES_INV_SBOX_EN
      inv_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work  <= in_state;
            cnt   <= '0;
            state <= BUSY;
`ifdef SUB_BYTES_INV_SBOX_EN
            inv_q <= inv_mode;
`endif
          end
        end
        BUSY: begin
          work <= work_next;
          if (cnt == LAST_GROUP) begin
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          // Returning to IDLE (rather than accepting here) leaves a one-cycle gap between blocks.
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_state = work;

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Directed bench for sub_bytes_engine: LANES=4 main instance plus LANES=1 and LANES=16 instances
// sharing the same stimulus for the latency comparison.
module tb_sub_bytes_engine;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         inv_mode;
  logic         out_ready;
  logic [127:0] in_state;

  logic         in_ready, out_valid, busy;
  logic [127:0] out_state;
  logic         in_ready_l1, out_valid_l1, busy_l1;
  logic [127:0] out_state_l1;
  logic         in_ready_l16, out_valid_l16, busy_l16;
  logic [127:0] out_state_l16;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sub_bytes_engine #(.LANES(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_state(in_state), .inv_mode(inv_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_state(out_state), .busy(busy)
  );

  sub_bytes_engine #(.LANES(1)) dut_l1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_l1),
    .in_state(in_state), .inv_mode(inv_mode), .out_valid(out_valid_l1),
    .out_ready(out_ready), .out_state(out_state_l1), .busy(busy_l1)
  );

  sub_bytes_engine #(.LANES(16)) dut_l16 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_l16),
    .in_state(in_state), .inv_mode(inv_mode), .out_valid(out_valid_l16),
    .out_ready(out_ready), .out_state(out_state_l16), .busy(busy_l16)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] fill(input logic [7:0] b);
    return {16{b}};
  endfunction

  // Offers one block on a negedge and returns at the negedge where out_valid is first seen.
  // lat counts clock edges after the accept edge; inputs are scribbled while the block is in flight.
  task automatic send(input logic [127:0] data, input logic inv, output int lat);
    @(negedge clk);
    in_state = data;
    inv_mode = inv;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_state = ~data;
    inv_mode = ~inv;
    lat = 0;
    while (!out_valid && lat < 64) begin
      @(negedge clk);
      lat++;
      inv_mode = ~inv_mode;
    end
  endtask

  task automatic release_out(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, 128'(out_valid), 128'(0));
    check({tag, "_ready_back"}, 128'(in_ready), 128'(1));
  endtask

  logic [7:0]   pat_in  [5] = '{8'h00, 8'hFF, 8'hAA, 8'hF0, 8'h0F};
  logic [7:0]   pat_out [5] = '{8'h63, 8'h16, 8'hAC, 8'h8C, 8'h76};
  logic [127:0] pin, pout;
  logic [127:0] blk [3];
  logic [127:0] bexp [3];
  int           acc [3];

  initial begin
    int lat, l1, l4, l16, c, nacc, nout, cyc;
    logic [127:0] s1, s4, s16;

    for (int k = 0; k < 16; k++) begin
      pin[8*k +: 8]  = pat_in[k % 5];
      pout[8*k +: 8] = pat_out[k % 5];
    end

    reset = 1'b1; in_valid = 1'b0; inv_mode = 1'b0; out_ready = 1'b0; in_state = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_out_state", out_state, 128'h0);
    reset = 1'b0;

    // All-zero block: latency 4, all bytes 63, held while out_ready stays low.
    send(128'h0, 1'b0, lat);
    check("zero_latency", 128'(lat), 128'(4));
    check("zero_data", out_state, fill(8'h63));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("zero_hold_valid", 128'(out_valid), 128'(1));
      check("zero_hold_data", out_state, fill(8'h63));
    end
    release_out("zero");

    // Mixed byte pattern with hold and release.
    send(pin, 1'b0, lat);
    check("pat_latency", 128'(lat), 128'(4));
    check("pat_data", out_state, pout);
    check("pat_busy_done", 128'(busy), 128'(1));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("pat_hold_data", out_state, pout);
    end
    release_out("pat");

    // Reset two edges after accept discards the block in flight.
    @(negedge clk);
    in_state = fill(8'hAA);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("mid_busy", 128'(busy), 128'(1));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_in_ready", 128'(in_ready), 128'(1));
    check("mid_rst_out_valid", 128'(out_valid), 128'(0));
    check("mid_rst_busy", 128'(busy), 128'(0));
    check("mid_rst_out_state", out_state, 128'h0);
    send(fill(8'hF0), 1'b0, lat);
    check("post_rst_latency", 128'(lat), 128'(4));
    check("post_rst_data", out_state, fill(8'h8C));
    release_out("post_rst");

`ifdef SUB_BYTES_INV_SBOX_EN
    send(fill(8'h63), 1'b1, lat);
    check("inv_63_data", out_state, 128'h0);
    release_out("inv_63");
    send(pout, 1'b1, lat);
    check("inv_pat_data", out_state, pin);
    release_out("inv_pat");
`else
    send(128'h0, 1'b1, lat);
    check("inv_ignored_data", out_state, fill(8'h63));
    release_out("inv_ignored");
`endif

    // Back-to-back with in_valid and out_ready held high.
    blk[0] = fill(8'hFF); bexp[0] = fill(8'h16);
    blk[1] = 128'h0;      bexp[1] = fill(8'h63);
    blk[2] = pin;         bexp[2] = pout;
    nacc = 0; nout = 0; cyc = 0;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    while (nout < 3 && cyc < 100) begin
      if (nacc == 3) in_valid = 1'b0;
      else in_state = blk[nacc];
      if (in_ready && in_valid) begin
        acc[nacc] = cyc;
        nacc++;
      end
      if (out_valid) begin
        check("b2b_out", out_state, bexp[nout]);
        nout++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("b2b_accepts", 128'(nacc), 128'(3));
    check("b2b_outputs", 128'(nout), 128'(3));
    check("b2b_gap_0_1", 128'(acc[1] - acc[0]), 128'(6));
    check("b2b_gap_1_2", 128'(acc[2] - acc[1]), 128'(6));

    // Latency across lane counts, all instances started from reset together.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    l1 = -1; l4 = -1; l16 = -1;
    s1 = '0; s4 = '0; s16 = '0;
    in_state = {16{8'hFF}};
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_state = '0;
    c = 0;
    while (c < 40 && (l1 < 0 || l4 < 0 || l16 < 0)) begin
      @(negedge clk);
      c++;
      if (out_valid_l1 && l1 < 0)   begin l1 = c;  s1 = out_state_l1;   end
      if (out_valid && l4 < 0)      begin l4 = c;  s4 = out_state;      end
      if (out_valid_l16 && l16 < 0) begin l16 = c; s16 = out_state_l16; end
    end
    check("lanes1_latency", 128'(l1), 128'(16));
    check("lanes4_latency", 128'(l4), 128'(4));
    check("lanes16_latency", 128'(l16), 128'(1));
    check("lanes1_data", s1, fill(8'h16));
    check("lanes4_data", s4, fill(8'h16));
    check("lanes16_data", s16, fill(8'h16));
    release_out("lanes");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule
